spi_fifo_master: RTL and testbench

SPI_FIFO_MASTER -- requirements
Module: spi_fifo_master

---
 rtl/spi_fifo_master.sv | 123 ++++++++++++
 tb/tb_spi_fifo_master.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_fifo_master.sv
// SPI mode-0 master that pops words from a TX FIFO, shifts them out MSB first,
// and pushes the received words into an RX FIFO. Back-to-back words keep cs_n low.
`timescale 1ns/1ps
module spi_fifo_master #(
    parameter int dw  = 8,
    parameter int cw  = 8,
    parameter int div = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [dw-1:0] tx_odat,
    input  logic          tx_empty,
    output logic          tx_oen,
    output logic [dw-1:0] rx_idat,
    input  logic          rx_full,
    output logic          rx_ien,
    output logic          sclk,
    output logic          mosi,
    input  logic          miso,
    output logic          cs_n,
    output logic          busy,
    output logic          ovf
);

    localparam int bw = $clog2(dw + 1);

    typedef enum logic [2:0] {IDLE, POP, WAIT, LOAD, SHIFT, PUSH, PUSHW, CSHOLD} state_t;

    state_t        state, state_nx;
    logic [cw-1:0] cnt;
    logic [bw-1:0] bits;
    logic [dw-1:0] tx_sr;
    logic [dw-1:0] rx_sr;
    logic          tc;

    assign tc = (cnt == cw'(div - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        tx_oen   = 1'b0;
        rx_ien   = 1'b0;
        busy     = (state != IDLE);
        case (state)
            IDLE:   if (tx_empty) state_nx = POP;
            POP: begin
                tx_oen   = 1'b1;
                state_nx = WAIT;
            end
            WAIT:   state_nx = LOAD;
            LOAD:   state_nx = SHIFT;
            // leave only on the falling edge that follows the last rising edge
            SHIFT:  if (tc && sclk && bits == bw'(dw)) state_nx = PUSH;
            PUSH: begin
                rx_ien   = rx_full;
                state_nx = PUSHW;
            end
            PUSHW:  state_nx = tx_empty ? POP : CSHOLD;
            CSHOLD: if (tc) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk    <= 1'b0;
            mosi    <= 1'b0;
            cs_n    <= 1'b1;
            rx_idat <= '0;
            ovf     <= 1'b0;
            cnt     <= '0;
            bits    <= '0;
            tx_sr   <= '0;
            rx_sr   <= '0;
        end else begin
            case (state)
                LOAD: begin
                    tx_sr <= tx_odat;
                    rx_sr <= '0;
                    mosi  <= tx_odat[dw-1];
                    cs_n  <= 1'b0;
                    cnt   <= '0;
                    bits  <= '0;
                    sclk  <= 1'b0;
                end
                SHIFT: begin
                    if (tc) begin
                        cnt  <= '0;
                        sclk <= ~sclk;
                        if (!sclk) begin
                            rx_sr <= {rx_sr[dw-2:0], miso};
                            bits  <= bits + 1'b1;
                        end else if (bits != bw'(dw)) begin
                            tx_sr <= {tx_sr[dw-2:0], 1'b0};
                            mosi  <= tx_sr[dw-2];
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PUSH: begin
                    if (rx_full) rx_idat <= rx_sr;
                    else         ovf     <= 1'b1;
                end
                PUSHW:  cnt <= '0;
                CSHOLD: begin
                    if (tc) begin
                        cs_n <= 1'b1;
                        cnt  <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_fifo_master.sv
// Directed bench for spi_fifo_master: FIFO models on both sides, loopback miso,
// edge monitors for pulse counts and SCLK spacing.
`timescale 1ns/1ps
module tb_spi_fifo_master;

    localparam int DW   = 8;
    localparam int DIV  = 2;
    localparam int CLKP = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] tx_odat;
    logic          tx_empty;
    logic          tx_oen;
    logic [DW-1:0] rx_idat;
    logic          rx_full;
    logic          rx_ien;
    logic          sclk, mosi, miso, cs_n, busy, ovf;

    logic          loop_en;
    logic          miso_r;

    int            errors = 0;
    int            checks = 0;

    logic [DW-1:0] tx_mem [0:15];
    int            tx_wr = 0;
    int            tx_rd = 0;

    int            rises, oen_cnt, ien_cnt, csn_falls, bad_sp, viol;
    logic [31:0]   mosi_bits;
    logic [31:0]   rx_log;
    time           t_rise, t_csrise, t_ienfall;
    logic          prev_oen = 1'b0, prev_ien = 1'b0;

    always #(CLKP/2) clk = ~clk;

    assign tx_empty = (tx_wr != tx_rd);
    assign miso     = loop_en ? mosi : miso_r;

    spi_fifo_master #(.dw(DW), .cw(8), .div(DIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_odat  (tx_odat),
        .tx_empty (tx_empty),
        .tx_oen   (tx_oen),
        .rx_idat  (rx_idat),
        .rx_full  (rx_full),
        .rx_ien   (rx_ien),
        .sclk     (sclk),
        .mosi     (mosi),
        .miso     (miso),
        .cs_n     (cs_n),
        .busy     (busy),
        .ovf      (ovf)
    );

    // TX FIFO acts on the falling edge of its pop strobe
    always @(negedge tx_oen) begin
        if (tx_rd != tx_wr) begin
            tx_odat = tx_mem[tx_rd % 16];
            tx_rd++;
        end
    end

    always @(posedge tx_oen) oen_cnt++;
    always @(posedge rx_ien) ien_cnt++;
    always @(negedge cs_n)   csn_falls++;
    always @(posedge cs_n)   t_csrise = $time;
    always @(negedge rx_ien) t_ienfall = $time;

    always @(negedge rx_ien) begin
        #1;
        rx_log = {rx_log[23:0], rx_idat};
    end

    always @(posedge sclk) begin
        if ((rises % DW) != 0 && ($time - t_rise) != 2 * DIV * CLKP) bad_sp++;
        t_rise    = $time;
        rises++;
        mosi_bits = {mosi_bits[30:0], mosi};
    end

    always @(negedge clk) begin
        if (tx_oen && rx_ien) viol++;
        if ((tx_oen || rx_ien) && (prev_oen || prev_ien)) viol++;
        prev_oen = tx_oen;
        prev_ien = rx_ien;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr_counts();
        rises     = 0;
        oen_cnt   = 0;
        ien_cnt   = 0;
        csn_falls = 0;
        bad_sp    = 0;
        mosi_bits = '0;
        rx_log    = '0;
    endtask

    task automatic push_tx(input logic [DW-1:0] d);
        tx_mem[tx_wr % 16] = d;
        tx_wr++;
    endtask

    task automatic run_xfer(input int budget);
        int n;
        n = 0;
        while (!busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq("xfer_done_in_budget", (n < budget), 1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int n;
        viol    = 0;
        rst     = 1'b0;
        loop_en = 1'b0;
        miso_r  = 1'($urandom_range(0, 1));
        rx_full = 1'($urandom_range(0, 1));
        tx_odat = 8'($urandom);
        clr_counts();
        repeat (3) @(negedge clk);
        push_tx(8'hA5);
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_ctrl_outs", {sclk, mosi, cs_n, tx_oen, rx_ien, busy, ovf}, 7'b0010000);
        check_eq("rst_rx_idat", rx_idat, 0);

        // single word with loopback
        loop_en = 1'b1;
        rx_full = 1'b1;
        clr_counts();
        @(negedge clk);
        rst = 1'b1;
        run_xfer(2000);
        check_eq("single_oen_pulses", oen_cnt, 1);
        check_eq("single_sclk_rises", rises, 8);
        check_eq("single_sclk_spacing", bad_sp, 0);
        check_eq("single_mosi_bits", mosi_bits, 32'h0000_00A5);
        check_eq("single_ien_pulses", ien_cnt, 1);
        check_eq("single_rx_idat", rx_idat, 8'hA5);
        check_eq("single_csn_falls", csn_falls, 1);
        check_eq("single_csn_hold", 32'(t_csrise - t_ienfall), (1 + DIV) * CLKP);
        check_eq("single_end_state", {cs_n, busy, sclk}, 3'b100);

        // TX FIFO empty for 100 cycles
        clr_counts();
        repeat (100) @(negedge clk);
        check_eq("empty_oen_pulses", oen_cnt, 0);
        check_eq("empty_rises", rises, 0);
        check_eq("empty_outs", {sclk, cs_n, busy}, 3'b010);

        // overflow: RX FIFO full at PUSH
        rx_full = 1'b0;
        clr_counts();
        push_tx(8'h3C);
        run_xfer(2000);
        check_eq("ovf_ien_pulses", ien_cnt, 0);
        check_eq("ovf_set", ovf, 1);
        check_eq("ovf_rx_idat_held", rx_idat, 8'hA5);
        rx_full = 1'b1;
        clr_counts();
        push_tx(8'h55);
        run_xfer(2000);
        check_eq("ovf_sticky", ovf, 1);
        check_eq("ovf2_rx_idat", rx_idat, 8'h55);
        check_eq("ovf2_ien_pulses", ien_cnt, 1);

        // back-to-back words under a single chip select
        clr_counts();
        push_tx(8'h01);
        push_tx(8'h02);
        push_tx(8'h03);
        run_xfer(4000);
        check_eq("b2b_csn_falls", csn_falls, 1);
        check_eq("b2b_rises", rises, 24);
        check_eq("b2b_spacing", bad_sp, 0);
        check_eq("b2b_ien_pulses", ien_cnt, 3);
        check_eq("b2b_oen_pulses", oen_cnt, 3);
        check_eq("b2b_rx_words", rx_log, 32'h0001_0203);
        check_eq("b2b_mosi_bits", mosi_bits, 32'h0001_0203);

        // reset asserted after the 4th rising SCLK edge
        clr_counts();
        push_tx(8'h96);
        n = 0;
        while (rises < 4 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_eq("midrst_reached_4_rises", rises, 4);
        #2;
        rst = 1'b0;
        #1;
        check_eq("midrst_async_outs", {sclk, cs_n, busy, tx_oen, rx_ien}, 5'b01000);
        repeat (3) @(negedge clk);
        check_eq("midrst_no_push", ien_cnt, 0);
        check_eq("midrst_ovf_cleared", {ovf, rx_idat}, 9'h000);
        rst = 1'b1;
        clr_counts();
        push_tx(8'hC3);
        run_xfer(2000);
        check_eq("post_rst_rises", rises, 8);
        check_eq("post_rst_mosi", mosi_bits, 32'h0000_00C3);
        check_eq("post_rst_rx_idat", rx_idat, 8'hC3);
        check_eq("post_rst_ien", ien_cnt, 1);

        check_eq("oen_ien_exclusive", viol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
